aes_bcd_scan_ctrl: RTL and testbench



---
 rtl/aes_bcd_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_aes_bcd_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_bcd_scan_ctrl.sv
// aes_bcd_scan_ctrl: walks a captured 128-bit AES state byte by byte through
// one shared 8-bit binary-to-BCD converter (shift_add_3). Each byte is
// presented as a registered 12-bit BCD result over a valid/ready handshake.
// After byte 15 is accepted, done pulses for one cycle.
//
// Optional feature macro: BCD_DWELL_EN
//   When it is defined, the FSM spends DWELL_CYCLES idle cycles between bytes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a scan; sampled only in IDLE
//   abort      in   synchronous cancel of a scan in progress
//   state_in   in   [127:0] AES state; byte 0 is state_in[127:120]
//   busy       out  FSM is not in IDLE
//   byte_idx   out  [3:0] index of the byte presented
//   bcd_out    out  [11:0] {hundreds, tens, ones}
//   out_valid  out  bcd_out/byte_idx are valid
//   out_ready  in   consumer accepts the result
//   done       out  one-cycle pulse after byte 15 is accepted

// Combinational 8-bit binary to 3-digit BCD converter using double dabble.
module shift_add_3 (
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);
    logic [19:0] sr;

    always_comb begin
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8]  >= 4'd5) sr[11:8]  = sr[11:8]  + 4'd3;
            if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
            sr = sr << 1;
        end
        bcd = sr[19:8];
    end
endmodule

module aes_bcd_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] state_in,
    output logic         busy,
    output logic [3:0]   byte_idx,
    output logic [11:0]  bcd_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         done
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

    // Reject illegal dwell lengths at elaboration.
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
        $error("aes_bcd_scan_ctrl: DWELL_CYCLES must be 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_OUT,
`ifdef BCD_DWELL_EN
        S_DWELL,
`endif
        S_DONE
    } state_t;

    state_t             st;
    logic [DATA_W-1:0]  sreg;
    logic [IDX_W-1:0]   idx;
    logic [BCD_W-1:0]   bcd_c;

`ifdef BCD_DWELL_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0]   cnt;
`endif

    // Single shared converter, always fed by the top byte of the shift register.
    shift_add_3 u_conv (
        .bin (sreg[DATA_W-1 -: BYTE_W]),
        .bcd (bcd_c)
    );

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_IDLE;
            sreg      <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            byte_idx  <= '0;
            bcd_out   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef BCD_DWELL_EN
            cnt       <= '0;
`endif
        end else begin
            case (st)
                S_IDLE: begin
                    if (start) begin
                        sreg <= state_in;
                        idx  <= '0;
                        busy <= 1'b1;
                        st   <= S_CONV;
                    end
                end

                S_CONV: begin
                    if (abort) begin
                        busy <= 1'b0;
                        st   <= S_IDLE;
                    end else begin
                        bcd_out   <= bcd_c;
                        byte_idx  <= idx;
                        out_valid <= 1'b1;
                        st        <= S_OUT;
                    end
                end

                S_OUT: begin
                    // Abort wins over a simultaneous handshake.
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        st        <= S_IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done <= 1'b1;
                            st   <= S_DONE;
                        end else begin
                            sreg <= sreg << BYTE_W;
                            idx  <= idx + IDX_W'(1);
`ifdef BCD_DWELL_EN
                            cnt  <= CNT_W'(DWELL_CYCLES - 1);
                            st   <= S_DWELL;
`else
                            st   <= S_CONV;
`endif
                        end
                    end
                end

`ifdef BCD_DWELL_EN
                S_DWELL: begin
                    if (abort) begin
                        busy <= 1'b0;
                        st   <= S_IDLE;
                    end else if (cnt == '0) begin
                        st <= S_CONV;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif

                S_DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    st        <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_bcd_scan_ctrl.sv
// Directed self-checking bench for aes_bcd_scan_ctrl.
module tb_aes_bcd_scan_ctrl;
    localparam int unsigned DW = 3;
`ifdef BCD_DWELL_EN
    localparam int GAP = 2 + DW;
`else
    localparam int GAP = 2;
`endif
    localparam logic [127:0] ST  = 128'h00090A6364C7FF80_0102030405060708;
    localparam logic [127:0] ALT = 128'hFFEEDDCCBBAA99887766554433221100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] state_in = '0;
    logic         busy;
    logic [3:0]   byte_idx;
    logic [11:0]  bcd_out;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [11:0] exp_bcd [16] = '{12'h000, 12'h009, 12'h010, 12'h099,
                                  12'h100, 12'h199, 12'h255, 12'h128,
                                  12'h001, 12'h002, 12'h003, 12'h004,
                                  12'h005, 12'h006, 12'h007, 12'h008};

    aes_bcd_scan_ctrl #(.DWELL_CYCLES(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .state_in  (state_in),
        .busy      (busy),
        .byte_idx  (byte_idx),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_scan(input logic [127:0] s, output int n);
        start = 1'b1;
        state_in = s;
        @(negedge clk);
        n = cyc;
        start = 1'b0;
    endtask

    task automatic expect_byte(input int k);
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("byte_valid", 32'(out_valid), 32'd1);
        chk("byte_bcd", 32'(bcd_out), 32'(exp_bcd[k]));
        chk("byte_idx", 32'(byte_idx), 32'(k));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int dc;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(byte_idx), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full scan, exact cycle timing
        start_scan(ST, n);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            wait_until(n + 1 + k * GAP);
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_bcd", 32'(bcd_out), 32'(exp_bcd[k]));
            chk("t1_idx", 32'(byte_idx), 32'(k));
            if (k < 15) begin
                wait_until(n + 2 + k * GAP);
                chk("t1_valid_drop", 32'(out_valid), 32'd0);
                chk("t1_busy", 32'(busy), 32'd1);
            end
        end
        wait_until(n + 2 + 15 * GAP);
        chk("t1_done_cycle", 32'(done), 32'd1);
        chk("t1_valid_in_done", 32'(out_valid), 32'd0);
        wait_until(n + 3 + 15 * GAP);
        chk("t1_done_low", 32'(done), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);

        // Back-to-back scan, start while busy at byte 7
        dc = done_cnt;
        start_scan(ST, n);
        for (int k = 0; k < 16; k++) begin
            expect_byte(k);
            if (k == 7) begin
                start = 1'b1;
                state_in = ALT;
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (5) @(negedge clk);
        chk("t3_one_done", 32'(done_cnt - dc), 32'd1);

        // Backpressure on byte 3
        start_scan(ST, n);
        for (int k = 0; k < 16; k++) begin
            expect_byte(k);
            if (k == 3) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(out_valid), 32'd1);
                    chk("bp_bcd", 32'(bcd_out), 32'h099);
                    chk("bp_idx", 32'(byte_idx), 32'd3);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        wait_done();

        // Abort at byte 5 together with out_ready
        dc = done_cnt;
        start_scan(ST, n);
        for (int k = 0; k < 5; k++) begin
            expect_byte(k);
            @(negedge clk);
        end
        expect_byte(5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        chk("abort_stays_idle", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-scan
        start_scan(ST, n);
        for (int k = 0; k < 2; k++) begin
            expect_byte(k);
            @(negedge clk);
        end
        expect_byte(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_bcd", 32'(bcd_out), 32'd0);
        chk("arst_idx", 32'(byte_idx), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_idle_busy", 32'(busy), 32'd0);

        // Fresh scan after reset still works
        start_scan(ST, n);
        for (int k = 0; k < 16; k++) begin
            expect_byte(k);
            @(negedge clk);
        end
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
